// File: rtl/add128_seq_ctrl.sv
// Sequential WIDTH-bit adder controller: one byte chunk per cycle through a shared external 9-bit adder slice.
// Optional signed-overflow output enabled by defining ADD128_SEQ_OVF_EN.
module add128_seq_ctrl #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [8:0]       add_a,
    output logic [8:0]       add_b,
    input  logic [9:0]       add_f,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef ADD128_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NCHUNK = WIDTH / 8;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef ADD128_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // The slice's LSB only absorbs the +1 used to inject the running carry.
    logic unused_add_lsb;
    assign unused_add_lsb = add_f[0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ADD128_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        add_a   = 9'd0;
        add_b   = 9'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // {x,1}+{y,c} puts x+y+c in bits [9:1]: the carry enters through the LSB.
                add_a = {a_q[{idx_q, 3'b000} +: 8], 1'b1};
                add_b = {b_q[{idx_q, 3'b000} +: 8], c_q};
                sum_d[{idx_q, 3'b000} +: 8] = add_f[8:1];
                c_d   = add_f[9];
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = add_f[9];
                    done_d  = 1'b1;
`ifdef ADD128_SEQ_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADD128_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADD128_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef ADD128_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_add128_seq_ctrl.sv
// Scoreboard bench for add128_seq_ctrl: directed operations push expected results, a negedge monitor checks each done pulse.
module tb_add128_seq_ctrl;

    localparam int W = 128;
    localparam int NCHUNK = W / 8;

    typedef logic [W:0] val_t;
    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic [8:0]   add_a, add_b;
    logic [9:0]   add_f;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef ADD128_SEQ_OVF_EN
    logic         ovf;
`endif

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   busy_cnt = 0;
    exp_t exp_q[$];

    add128_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .add_a (add_a),
        .add_b (add_b),
        .add_f (add_f),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef ADD128_SEQ_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    // External shared 9-bit adder slice.
    assign add_f = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input val_t act, input val_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: busy length, latency and result are checked on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !busy) busy_cnt = 0;
        else busy_cnt++;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", val_t'(1), val_t'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sum", val_t'(sum), val_t'(e.sum));
                chk("cout", val_t'(cout), val_t'(e.cout));
                chk("done_cycle", val_t'(cyc), val_t'(e.done_cyc));
                chk("busy_len", val_t'(busy_cnt), val_t'(NCHUNK + 1));
`ifdef ADD128_SEQ_OVF_EN
                chk("ovf", val_t'(ovf), val_t'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge with the block idle; start is accepted at the next edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] esum,
                         input logic ecout, input logic eovf);
        exp_t e;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        e.sum = esum; e.cout = ecout; e.ovf = eovf; e.done_cyc = cyc + NCHUNK + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        chk("pending_after_timeout", val_t'(exp_q.size()), val_t'(0));
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        exp_t e1, e2;
        int   k;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", val_t'(busy), val_t'(0));
        chk("rst_done", val_t'(done), val_t'(0));
        chk("rst_sum", val_t'(sum), val_t'(0));
        chk("rst_cout", val_t'(cout), val_t'(0));
        chk("rst_add_a", val_t'(add_a), val_t'(0));
        chk("rst_add_b", val_t'(add_b), val_t'(0));
`ifdef ADD128_SEQ_OVF_EN
        chk("rst_ovf", val_t'(ovf), val_t'(0));
`endif

        // Scenario 1, started on the very first edge out of reset.
        rst_n = 1'b1;
        issue(128'd1, 128'd2, 1'b0, 128'd3, 1'b0, 1'b0);
        chk("busy_after_accept", val_t'(busy), val_t'(1));
        wait_idle();
        chk("add_a_idle", val_t'(add_a), val_t'(0));
        chk("hold_sum", val_t'(sum), val_t'(3));

        // Scenario 2: carry through every chunk.
        issue({W{1'b1}}, 128'd0, 1'b1, 128'd0, 1'b1, 1'b0);
        wait_idle();

        // Scenario 3.
        issue(128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
              128'h0100_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
        wait_idle();

        // Scenario 4: start held high, operands changed mid-RUN.
        k = cyc;
        a = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
        b = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
        cin = 1'b0; start = 1'b1;
        e1.sum = 128'd0;   e1.cout = 1'b1; e1.ovf = 1'b0; e1.done_cyc = k + NCHUNK + 1;
        e2.sum = 128'h0F;  e2.cout = 1'b0; e2.ovf = 1'b0; e2.done_cyc = k + 2 * NCHUNK + 3;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        repeat (5) @(negedge clk);
        a = 128'h5; b = 128'hA;
        repeat (20) @(negedge clk);
        a = 128'h1234_5678; b = 128'h9ABC_DEF0; start = 1'b0;
        wait_idle();

        // Scenario 5: reset in the middle of RUN.
        a = 128'h77; b = 128'h88; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", val_t'(busy), val_t'(0));
        chk("midrst_sum", val_t'(sum), val_t'(0));
        chk("midrst_cout", val_t'(cout), val_t'(0));
        chk("midrst_done", val_t'(done), val_t'(0));
        chk("midrst_add_a", val_t'(add_a), val_t'(0));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_rst", val_t'(busy), val_t'(0));
        issue(128'hFF, 128'h1, 1'b1, 128'h101, 1'b0, 1'b0);
        wait_idle();

        // Scenario 6 and signed-overflow corners.
        issue(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
              128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
        wait_idle();
        issue(128'd1, 128'd1, 1'b0, 128'd2, 1'b0, 1'b0);
        wait_idle();
        issue(128'h8000_0000_0000_0000_0000_0000_0000_0000,
              128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0,
              128'd0, 1'b1, 1'b1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/add128_seq_ctrl.md
ADD128_SEQ_CTRL -- requirements
Module: add128_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, operand width in bits; legal values are multiples of 8, from 16 to 256.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin one addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a, b, input, WIDTH, unsigned operands, captured when start is accepted.
REQ-006 The block SHALL have port cin, input, 1, carry-in, captured when start is accepted.
REQ-007 The block SHALL have ports add_a, add_b, output, 9, operands driven to the shared external 9-bit adder slice.
REQ-008 The block SHALL have port add_f, input, 10, combinational result returned by that adder slice.
REQ-009 The block SHALL have port busy, output, 1, high in RUN and DONE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have ports sum, output, WIDTH, and cout, output, 1, the result and the carry-out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a, b and cin, clear the chunk index idx to 0, and enter RUN; in IDLE with start=0, it SHALL stay in IDLE.
REQ-014 In RUN, the block SHALL drive add_a={a_q[8*idx+7:8*idx],1'b1} and add_b={b_q[8*idx+7:8*idx],c_q}, where c_q is the running carry, initialised to cin.
REQ-015 Each RUN cycle, the block SHALL write add_f[8:1] into sum[8*idx+7:8*idx], load c_q<=add_f[9], and increment idx.
REQ-016 RUN SHALL last exactly WIDTH/8 cycles; after the cycle with idx=WIDTH/8-1, the block SHALL enter DONE with cout=final c_q.
REQ-017 The block SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-018 Start-accept-edge to done-high latency SHALL be WIDTH/8+1 clocks, i.e. 17 for the default.
REQ-019 Outside RUN, add_a and add_b SHALL be driven to 0.
REQ-020 start SHALL be ignored in RUN and DONE, with no queuing; a start held high in DONE is accepted on the following IDLE cycle.
REQ-021 sum and cout SHALL hold their last result until the next accepted start.
REQ-022 sum chunks not yet written in the current operation SHALL hold their previous value; only the final sum is valid.
REQ-023 Operand changes on a and b after acceptance SHALL not affect the result.
REQ-024 Carry SHALL ripple across chunk boundaries with no truncation: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL go to state IDLE, and idx, c_q, a_q, b_q, sum, cout, done and ovf SHALL all become 0.
REQ-026 When rst_n=0 at a rising edge, add_a and add_b SHALL be driven to 0.
REQ-027 Reset SHALL take priority over start and over an in-progress RUN; a partial result is discarded with no done pulse.
REQ-028 On the first edge with rst_n=1, the block SHALL be in IDLE and able to accept start.

Configuration
REQ-029 Macro ADD128_SEQ_OVF_EN SHALL control the signed-overflow feature.
REQ-030 With ADD128_SEQ_OVF_EN defined, the block SHALL add output port ovf (1 bit), registered on entry to DONE as (a_q[WIDTH-1]==b_q[WIDTH-1]) && (sum[WIDTH-1]!=a_q[WIDTH-1]); ovf holds like sum and resets to 0.
REQ-031 Without ADD128_SEQ_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario 1: a=1, b=2, cin=0, start pulse -> done high 17 clocks after acceptance, sum=3, cout=0, busy high for 17 cycles.
REQ-033 Scenario 2: a=all-ones, b=0, cin=1 -> sum=0, cout=1; carry ripples through all 16 chunks.
REQ-034 Scenario 3: a=0x00FF...FF (upper byte 0), b=1, cin=0 -> sum=0x0100...00, cout=0.
REQ-035 Scenario 4: start held high continuously -> back-to-back operations with done spaced 18 clocks apart; operand change mid-RUN is ignored.
REQ-036 Scenario 5: rst_n=0 at RUN cycle 7 -> next cycle IDLE, busy=0, sum=0, no done; a new start then completes normally.
REQ-037 Scenario 6 (ADD128_SEQ_OVF_EN defined): a=0x7FFF...FF, b=1 -> ovf=1, cout=0; a=1, b=1 -> ovf=0.
